mod_operand_mult: RTL and testbench

- Sequential radix-2 shift-add multiplier that produces the 2*width-bit product consumed by the modular reduction stage.
- Acts as the producer end of the reducer's enable/done interface: `product` and `done` are wired to the reducer's `a` and `enable`.
- Sits in the MSM field-arithmetic datapath between operand registers and the reducer.

---
 rtl/mod_operand_mult.sv | 117 +++++++++++
 tb/tb_mod_operand_mult.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_operand_mult.sv
// Radix-2 shift-add multiplier feeding the modular reducer (product/done -> a/enable).
// Optional MOD_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mod_operand_mult #(
    parameter int width = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*width-1:0]   product
);

    localparam int CW = (width > 1) ? $clog2(width) : 1;
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2*width-1:0] mcand_q, mcand_d;
    logic [width-1:0]   mplier_q, mplier_d;
    logic [2*width-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*width-1:0] product_q, product_d;

    logic [2*width-1:0] acc_sum;
    logic [width-1:0]   mplier_sh;
    logic               last_cycle;
    logic               accept;

    assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_sh = mplier_q >> 1;

`ifdef MOD_MULT_EARLY_EXIT_EN
    assign last_cycle = (count_q == LAST) || (mplier_sh == '0);
`else
    assign last_cycle = (count_q == LAST);
`endif

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = done_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mcand_d  = {{width{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_sh;
                count_d  = count_q + CW'(1);
                // product only moves here, so the reducer never sees partial sums
                if (last_cycle) begin
                    product_d = acc_sum;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mod_operand_mult.sv
// Self-checking bench for mod_operand_mult at width=8.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_mod_operand_mult;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_pass  = 0;
    int n_total = 0;

    mod_operand_mult #(.width(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Cycles from accepting edge to done edge.
    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef MOD_MULT_EARLY_EXIT_EN
        int h = 1;
        for (int i = 0; i < W; i++) if (bv[i]) h = i + 1;
        return h;
`else
        return W;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        repeat (4 * W) begin
            tick();
            lat++;
            if (done) return;
        end
        lat = -1;
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int l2;
        logic ok;
        logic [W-1:0] ra, rb;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
        vecs[5] = '{a: 8'd128, b: 8'd2,   p: 16'd256};

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        reset = 1'b0;
        tick();
        check("idle_done", done, 0);

        // 13*11: busy across the run, then result held
        a = 8'd13;
        b = 8'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_busy", busy, 1);
        check("run_done_low", done, 0);
        wait_done(lat);
        check("basic_lat", lat, exp_lat(8'd11));
        check("basic_product", product, 143);
        check("basic_busy_low", busy, 0);
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (!done || product != 16'd143 || busy) ok = 1'b0;
        end
        check("hold_stable", ok, 1);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_product", i), product, vecs[i].p);
            check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].b));
        end

        // start while busy must be ignored
        a = 8'd7;
        b = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'd3;
        b = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignore_busy", busy, 1);
        wait_done(l2);
        lat = (l2 < 0) ? -1 : l2 + 3;
        check("ignore_lat", lat, exp_lat(8'd9));
        check("ignore_product", product, 63);
        tick();
        check("ignore_no_restart", busy, 0);

        // reset in the middle of a run
        a = 8'd200;
        b = 8'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        run_op(8'd5, 8'd6, lat);
        check("midrst_next_product", product, 30);
        check("midrst_next_lat", lat, exp_lat(8'd6));

        // back-to-back: old product held until the new completion edge
        run_op(8'd13, 8'd11, lat);
        check("b2b_first", product, 143);
        a = 8'd2;
        b = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_done_drop", done, 0);
        check("b2b_hold0", product, 143);
        ok = 1'b1;
        lat = -1;
        for (int c = 1; c <= 4 * W; c++) begin
            tick();
            if (done) begin
                lat = c;
                break;
            end
            if (product != 16'd143) ok = 1'b0;
        end
        check("b2b_hold", ok, 1);
        check("b2b_lat", lat, exp_lat(8'd3));
        check("b2b_product", product, 6);

        // randomized operands against a*b
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = (i % 4 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            run_op(ra, rb, lat);
            check($sformatf("rnd%0d_product", i), product,
                  longint'(ra) * longint'(rb));
            check($sformatf("rnd%0d_lat", i), lat, exp_lat(rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
